// File: rtl/riscv_regfile.sv
// Integer register file with per-register pending-write counters so decode can
// see RAW hazards against in-flight write-backs. Reads are combinational with write-through bypass.
module riscv_regfile #(
  parameter  int REGFILE_COUNT = 32,
  parameter  int WORD_SIZE     = 32,
  parameter  int PEND_W        = 2,
  localparam int AW            = $clog2(REGFILE_COUNT)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AW-1:0]        read_reg0_i,
  input  logic [AW-1:0]        read_reg1_i,
  output logic [WORD_SIZE-1:0] read_data0_o,
  output logic [WORD_SIZE-1:0] read_data1_o,
  output logic                 busy0_o,
  output logic                 busy1_o,
  input  logic                 issue_en_i,
  input  logic [AW-1:0]        issue_reg_i,
  output logic                 issue_ready_o,
  input  logic                 write_en_i,
  input  logic [AW-1:0]        write_reg_i,
  input  logic [WORD_SIZE-1:0] write_data_i
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [WORD_SIZE-1:0] regs_q [REGFILE_COUNT];
  logic [WORD_SIZE-1:0] regs_d [REGFILE_COUNT];
  logic [PEND_W-1:0]    pend_q [REGFILE_COUNT];
  logic [PEND_W-1:0]    pend_d [REGFILE_COUNT];
  logic                 issue_acc_s;
  logic                 issue_hit_s;
  logic                 wr_hit_s;

  // Next state for storage and counters; x0 is never written.
  always_comb begin
    issue_acc_s = issue_en_i & issue_ready_o;
    issue_hit_s = 1'b0;
    wr_hit_s    = 1'b0;
    regs_d[0]   = '0;
    pend_d[0]   = '0;
    for (int r = 1; r < REGFILE_COUNT; r++) begin
      regs_d[r] = regs_q[r];
      pend_d[r] = pend_q[r];
      if (!rst_ni) begin
        regs_d[r] = '0;
        pend_d[r] = '0;
      end else begin
        issue_hit_s = issue_acc_s && (issue_reg_i == AW'(r));
        wr_hit_s    = write_en_i && (write_reg_i == AW'(r));
        if (wr_hit_s) begin
          regs_d[r] = write_data_i;
        end else begin
          regs_d[r] = regs_q[r];
        end
        // Issue and write-back to the same register cancel out.
        case ({issue_hit_s, wr_hit_s})
          2'b10:   pend_d[r] = pend_q[r] + PEND_ONE;
          2'b01: begin
            if (pend_q[r] != '0) begin
              pend_d[r] = pend_q[r] - PEND_ONE;
            end else begin
              pend_d[r] = pend_q[r];
            end
          end
          default: pend_d[r] = pend_q[r];
        endcase
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < REGFILE_COUNT; r++) begin
      regs_q[r] <= regs_d[r];
      pend_q[r] <= pend_d[r];
    end
  end

  // Read port 0 with bypass and hazard flag.
  always_comb begin
    read_data0_o = '0;
    busy0_o      = 1'b0;
    if (!rst_ni || read_reg0_i == '0) begin
      read_data0_o = '0;
      busy0_o      = 1'b0;
    end else if (write_en_i && write_reg_i == read_reg0_i) begin
      read_data0_o = write_data_i;
      busy0_o      = (pend_q[read_reg0_i] != '0) && (pend_q[read_reg0_i] != PEND_ONE);
    end else begin
      read_data0_o = regs_q[read_reg0_i];
      busy0_o      = (pend_q[read_reg0_i] != '0);
    end
  end

  // Read port 1 with bypass and hazard flag.
  always_comb begin
    read_data1_o = '0;
    busy1_o      = 1'b0;
    if (!rst_ni || read_reg1_i == '0) begin
      read_data1_o = '0;
      busy1_o      = 1'b0;
    end else if (write_en_i && write_reg_i == read_reg1_i) begin
      read_data1_o = write_data_i;
      busy1_o      = (pend_q[read_reg1_i] != '0) && (pend_q[read_reg1_i] != PEND_ONE);
    end else begin
      read_data1_o = regs_q[read_reg1_i];
      busy1_o      = (pend_q[read_reg1_i] != '0);
    end
  end

  // Issue back-pressure when the destination counter is saturated.
  always_comb begin
    if (!rst_ni) begin
      issue_ready_o = 1'b0;
    end else if (issue_reg_i == '0) begin
      issue_ready_o = 1'b1;
    end else begin
      issue_ready_o = (pend_q[issue_reg_i] != PEND_MAX);
    end
  end

endmodule

// File: tb/tb_riscv_regfile.sv
// Randomized and directed bench for riscv_regfile against an array-based
// model of registers and outstanding-write counts.
module tb_riscv_regfile;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  read_reg0_i, read_reg1_i, issue_reg_i, write_reg_i;
  logic [31:0] read_data0_o, read_data1_o, write_data_i;
  logic        busy0_o, busy1_o, issue_en_i, issue_ready_o, write_en_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_regs [32];
  int          m_pend [32];

  logic [31:0] obs_rd0, obs_rd1;
  logic        obs_b0, obs_b1, obs_rdy;

  riscv_regfile dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .read_reg0_i(read_reg0_i), .read_reg1_i(read_reg1_i),
    .read_data0_o(read_data0_o), .read_data1_o(read_data1_o),
    .busy0_o(busy0_o), .busy1_o(busy1_o),
    .issue_en_i(issue_en_i), .issue_reg_i(issue_reg_i), .issue_ready_o(issue_ready_o),
    .write_en_i(write_en_i), .write_reg_i(write_reg_i), .write_data_i(write_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (!rst_ni || idx == 5'd0) return 32'd0;
    if (write_en_i && write_reg_i == idx) return write_data_i;
    return m_regs[idx];
  endfunction

  function automatic logic exp_busy(input logic [4:0] idx);
    if (!rst_ni || idx == 5'd0) return 1'b0;
    if (write_en_i && write_reg_i == idx && m_pend[idx] == 1) return 1'b0;
    return m_pend[idx] != 0;
  endfunction

  function automatic logic exp_ready();
    if (!rst_ni) return 1'b0;
    return (issue_reg_i == 5'd0) || (m_pend[issue_reg_i] != 3);
  endfunction

  // One cycle: drive, check at negedge against the model, then advance the model at posedge.
  task automatic step(input logic rst, input logic ie, input logic [4:0] ir,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic [4:0] r0, input logic [4:0] r1);
    logic acc;
    rst_ni = rst; issue_en_i = ie; issue_reg_i = ir;
    write_en_i = we; write_reg_i = wr; write_data_i = wd;
    read_reg0_i = r0; read_reg1_i = r1;
    @(negedge clk_i);
    obs_rd0 = read_data0_o; obs_rd1 = read_data1_o;
    obs_b0 = busy0_o; obs_b1 = busy1_o; obs_rdy = issue_ready_o;
    check("rd0", obs_rd0, exp_read(r0));
    check("rd1", obs_rd1, exp_read(r1));
    check("busy0", {31'd0, obs_b0}, {31'd0, exp_busy(r0)});
    check("busy1", {31'd0, obs_b1}, {31'd0, exp_busy(r1)});
    check("ready", {31'd0, obs_rdy}, {31'd0, exp_ready()});
    acc = ie && exp_ready();
    @(posedge clk_i);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_pend[i] = 0; end
    end else begin
      if (acc && ir != 5'd0) m_pend[ir] = m_pend[ir] + 1;
      if (we && wr != 5'd0) begin
        m_regs[wr] = wd;
        if (m_pend[wr] > 0) m_pend[wr] = m_pend[wr] - 1;
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_pend[i] = 0; end
    #1;
    // Reset: outputs forced low.
    step(1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd0);
    check("rst_rd0", obs_rd0, 32'd0);
    check("rst_ready", {31'd0, obs_rdy}, 32'd0);
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Basic write then read.
    step(1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6);
    check("t1_x5", obs_rd0, 32'hDEADBEEF);
    check("t1_x6", obs_rd1, 32'd0);
    check("t1_busy", {31'd0, obs_b0}, 32'd0);

    // x0 is hardwired.
    step(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
    check("t2_x0_same", obs_rd0, 32'd0);
    check("t2_x0_ready", {31'd0, obs_rdy}, 32'd1);
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("t2_x0_next", obs_rd0, 32'd0);
    check("t2_x0_busy", {31'd0, obs_b0}, 32'd0);

    // Bypass on port 1, port 0 unaffected.
    step(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 32'h88, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd8, 5'd7);
    check("t3_bypass", obs_rd1, 32'hA5A5A5A5);
    check("t3_other", obs_rd0, 32'h88);

    // Scoreboard saturation and drain on x3.
    repeat (3) step(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    step(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    check("t4_sat_ready", {31'd0, obs_rdy}, 32'd0);
    check("t4_sat_busy", {31'd0, obs_b0}, 32'd1);
    step(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 32'h31, 5'd3, 5'd0);
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    check("t4_pend2_busy", {31'd0, obs_b0}, 32'd1);
    step(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 32'h32, 5'd3, 5'd0);
    step(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 32'h33, 5'd3, 5'd0);
    check("t4_last_busy", {31'd0, obs_b0}, 32'd0);
    check("t4_last_data", obs_rd0, 32'h33);

    // Simultaneous issue and write-back; spurious write-back.
    step(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    check("t5_busy_next", {31'd0, obs_b0}, 32'd1);
    step(1'b1, 1'b0, 5'd0, 1'b1, 5'd10, 32'hA0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd0);
    check("t5_spur_data", obs_rd0, 32'hA0);
    check("t5_spur_busy", {31'd0, obs_b0}, 32'd0);

    // Reset mid-operation.
    step(1'b1, 1'b0, 5'd0, 1'b1, 5'd4, 32'h55, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
    step(1'b0, 1'b0, 5'd4, 1'b1, 5'd4, 32'h77, 5'd4, 5'd4);
    check("t6_rst_rd", obs_rd0, 32'd0);
    check("t6_rst_busy", {31'd0, obs_b0}, 32'd0);
    step(1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 32'd0, 5'd4, 5'd4);
    check("t6_post_rd", obs_rd0, 32'd0);
    check("t6_post_busy", {31'd0, obs_b0}, 32'd0);
    check("t6_post_ready", {31'd0, obs_rdy}, 32'd1);

    // Random traffic on a small register window to provoke hazards.
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
